// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register with two-entry skid buffer, flush/bubble and stall counter
// Ports: clk_i/rst_i clock and sync active-high reset; valid_i/ready_o/ctrl_i/data_i upstream side;
// flush_i drops held and offered entries; valid_o/ready_i/ctrl_o/data_o downstream side;
// stall_cnt_o saturating count of cycles with valid_o high and ready_i low.
module pipe_stage_reg #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 111,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic accept, take, load_in, load_skid, promote;
  assign ready_o = !rst_i && state != SKID;
  assign valid_o = state != EMPTY;
  assign ctrl_o = valid_o ? main_ctrl : BUBBLE_CTRL;
  assign data_o = main_data;
  assign accept = valid_i && ready_o && !flush_i;
  assign take = valid_o && ready_i;
  always_comb begin
    state_nxt = state;
    load_in = 1'b0;
    load_skid = 1'b0;
    promote = 1'b0;
    case (state)
      EMPTY: begin
        load_in = accept;
        state_nxt = accept ? FULL : EMPTY;
      end
      FULL: begin
        load_in = accept && take;
        load_skid = accept && !take;
        state_nxt = accept ? (take ? FULL : SKID) : (take ? EMPTY : FULL);
      end
      SKID: begin
        promote = take;
        state_nxt = take ? FULL : SKID;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush_i) state_nxt = EMPTY;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else state <= state_nxt;
  end
  // Payload registers need no flush clear: the state alone marks them dead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_in) begin
        main_ctrl <= ctrl_i;
        main_data <= data_i;
      end else if (promote) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= ctrl_i;
        skid_data <= data_i;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_o <= '0;
    else if (valid_o && !ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
  end
endmodule
